// File: rtl/uart_defs_pkg.sv
// Shared 8N1 UART definitions: receiver state encoding and frame constants.
// The command decoder imports the same package.
`timescale 1ns/1ps
package uart_defs_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter. tick_o is high while the count sits at zero.
`timescale 1ns/1ps
module uart_bit_timer #(
  parameter int COUNTER_WIDTH = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [COUNTER_WIDTH-1:0] load_val_i,
  output logic                     tick_o
);

  logic [COUNTER_WIDTH-1:0] count_q;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - COUNTER_WIDTH'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign tick_o = (count_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, start/stop validation,
// one-cycle data_valid / framing_error strobes and a frame-busy flag.
`timescale 1ns/1ps
module uart_receiver
  import uart_defs_pkg::*;
#(
  parameter int CLK_PER_BIT   = 1154,
  parameter int HALF_BIT      = CLK_PER_BIT / 2,
  parameter int COUNTER_WIDTH = $clog2(CLK_PER_BIT)
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       running
);

  logic                     rx_meta_q;
  logic                     rx_sync_q;
  logic                     rx_s;
  uart_state_e              state_q;
  logic [2:0]               bit_idx_q;
  logic [7:0]               shift_q;
  logic [7:0]               data_q;
  logic                     data_valid_q;
  logic                     framing_error_q;
  logic                     running_q;
  logic                     timer_load_s;
  logic [COUNTER_WIDTH-1:0] timer_val_s;
  logic                     bit_tick_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_s = rx_sync_q;

  // Timer reload: half a bit from the start edge, then one full bit per sample.
  always_comb begin
    timer_load_s = 1'b0;
    timer_val_s  = COUNTER_WIDTH'(CLK_PER_BIT - 1);
    case (state_q)
      IDLE: begin
        timer_load_s = ~rx_s;
        timer_val_s  = COUNTER_WIDTH'(HALF_BIT - 1);
      end
      START, DATA: begin
        timer_load_s = bit_tick_s;
        timer_val_s  = COUNTER_WIDTH'(CLK_PER_BIT - 1);
      end
      default: begin
        timer_load_s = 1'b0;
        timer_val_s  = COUNTER_WIDTH'(CLK_PER_BIT - 1);
      end
    endcase
  end

  uart_bit_timer #(
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_bit_timer (
    .clk_i      (clk_in),
    .rst_ni     (reset),
    .load_i     (timer_load_s),
    .load_val_i (timer_val_s),
    .tick_o     (bit_tick_s)
  );

  // Frame FSM with registered strobes; running stays high through the strobe cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      data_q          <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          running_q <= ~rx_s;
          if (!rx_s) begin
            state_q <= START;
          end
        end
        START: begin
          if (bit_tick_s) begin
            if (rx_s) begin
              state_q   <= IDLE;
              running_q <= 1'b0;
            end else begin
              bit_idx_q <= 3'd0;
              state_q   <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_tick_s) begin
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_tick_s) begin
            if (rx_s) begin
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= BREAK;
            end
          end
        end
        // A held-low line must return high before another start is accepted.
        BREAK: begin
          running_q <= 1'b0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out      = data_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign running       = running_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit (10 ns clock, 160 ns bit).
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CPB    = 16;
  localparam int HB     = 8;
  localparam int BIT_NS = 160;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       running;

  int vectors     = 0;
  int miscompares = 0;

  int         cyc           = 0;
  int         dv_count      = 0;
  int         fe_count      = 0;
  int         both_count    = 0;
  int         run_cycles    = 0;
  int         last_dv_cycle = 0;
  int         prev_dv_cycle = 0;
  int         last_fe_cycle = 0;
  logic [7:0] last_dv_data  = 8'h00;
  logic [7:0] prev_dv_data  = 8'h00;
  logic       dv_prev       = 1'b0;
  logic       run_after_dv  = 1'b1;

  always #5 clk_in = ~clk_in;

  uart_receiver #(
    .CLK_PER_BIT (CPB),
    .HALF_BIT    (HB)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .running       (running)
  );

  always @(posedge clk_in) cyc <= cyc + 1;

  // Event recorder sampled on the inactive edge.
  always @(negedge clk_in) begin
    dv_prev <= data_valid;
    if (dv_prev) run_after_dv <= running;
    if (data_valid) begin
      dv_count      <= dv_count + 1;
      prev_dv_cycle <= last_dv_cycle;
      prev_dv_data  <= last_dv_data;
      last_dv_cycle <= cyc;
      last_dv_data  <= data_out;
    end
    if (framing_error) begin
      fe_count      <= fe_count + 1;
      last_fe_cycle <= cyc;
    end
    if (data_valid && framing_error) both_count <= both_count + 1;
    if (running) run_cycles <= run_cycles + 1;
  end

  task automatic align(output int n);
    @(posedge clk_in);
    #2;
    n = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_lvl, input int stop_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_lvl;
    #(stop_ns);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    idle(3);
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    vectors++; if (framing_error !== 1'b0) begin miscompares++; $display("FAIL reset_framing_error got=%b exp=0", framing_error); end
    vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running got=%b exp=0", running); end
    reset = 1'b1;
    idle(5);
  endtask

  task automatic test_single_byte;
    int n, dv0, run0;
    align(n);
    dv0 = dv_count; run0 = run_cycles;
    send_frame(8'h55, BIT_NS, 1'b1, BIT_NS);
    idle(20);
    vectors++; if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL single_dv_count got=%0d exp=1", dv_count - dv0); end
    vectors++; if (last_dv_cycle !== n + 155) begin miscompares++; $display("FAIL single_dv_cycle got=%0d exp=%0d", last_dv_cycle, n + 155); end
    vectors++; if (last_dv_data !== 8'h55) begin miscompares++; $display("FAIL single_dv_data got=%h exp=55", last_dv_data); end
    vectors++; if (data_out !== 8'h55) begin miscompares++; $display("FAIL single_data_out got=%h exp=55", data_out); end
    vectors++; if (run_after_dv !== 1'b0) begin miscompares++; $display("FAIL single_run_after got=%b exp=0", run_after_dv); end
    vectors++; if (run_cycles - run0 !== 153) begin miscompares++; $display("FAIL single_run_len got=%0d exp=153", run_cycles - run0); end
  endtask

  task automatic test_glitch;
    int n, dv0, fe0, run0;
    align(n);
    dv0 = dv_count; fe0 = fe_count; run0 = run_cycles;
    rx = 1'b0;
    #40;
    rx = 1'b1;
    idle(30);
    vectors++; if (dv_count - dv0 !== 0) begin miscompares++; $display("FAIL glitch_dv got=%0d exp=0", dv_count - dv0); end
    vectors++; if (fe_count - fe0 !== 0) begin miscompares++; $display("FAIL glitch_fe got=%0d exp=0", fe_count - fe0); end
    vectors++; if (run_cycles - run0 !== 8) begin miscompares++; $display("FAIL glitch_run_len got=%0d exp=8", run_cycles - run0); end
    vectors++; if (data_out !== 8'h55) begin miscompares++; $display("FAIL glitch_data_out got=%h exp=55", data_out); end
  endtask

  task automatic test_framing_error;
    int n, dv0, fe0, run0;
    align(n);
    send_frame(8'h3C, BIT_NS, 1'b1, BIT_NS);
    idle(10);
    vectors++; if (data_out !== 8'h3C) begin miscompares++; $display("FAIL fe_first_byte got=%h exp=3c", data_out); end
    align(n);
    dv0 = dv_count; fe0 = fe_count; run0 = run_cycles;
    send_frame(8'hA3, BIT_NS, 1'b0, 3 * BIT_NS);
    idle(10);
    vectors++; if (fe_count - fe0 !== 1) begin miscompares++; $display("FAIL fe_count got=%0d exp=1", fe_count - fe0); end
    vectors++; if (last_fe_cycle !== n + 155) begin miscompares++; $display("FAIL fe_cycle got=%0d exp=%0d", last_fe_cycle, n + 155); end
    vectors++; if (dv_count - dv0 !== 0) begin miscompares++; $display("FAIL fe_no_dv got=%0d exp=0", dv_count - dv0); end
    vectors++; if (data_out !== 8'h3C) begin miscompares++; $display("FAIL fe_data_held got=%h exp=3c", data_out); end
    vectors++; if (run_cycles - run0 !== 153) begin miscompares++; $display("FAIL fe_break_run got=%0d exp=153", run_cycles - run0); end
    align(n);
    dv0 = dv_count;
    send_frame(8'h12, BIT_NS, 1'b1, BIT_NS);
    idle(20);
    vectors++; if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL fe_recover_dv got=%0d exp=1", dv_count - dv0); end
    vectors++; if (data_out !== 8'h12) begin miscompares++; $display("FAIL fe_recover_data got=%h exp=12", data_out); end
  endtask

  task automatic test_back_to_back;
    int n, dv0;
    align(n);
    dv0 = dv_count;
    send_frame(8'h00, BIT_NS, 1'b1, BIT_NS);
    send_frame(8'hFF, BIT_NS, 1'b1, BIT_NS);
    idle(20);
    vectors++; if (dv_count - dv0 !== 2) begin miscompares++; $display("FAIL b2b_count got=%0d exp=2", dv_count - dv0); end
    vectors++; if (prev_dv_cycle !== n + 155) begin miscompares++; $display("FAIL b2b_first_cycle got=%0d exp=%0d", prev_dv_cycle, n + 155); end
    vectors++; if (last_dv_cycle - prev_dv_cycle !== 160) begin miscompares++; $display("FAIL b2b_spacing got=%0d exp=160", last_dv_cycle - prev_dv_cycle); end
    vectors++; if (prev_dv_data !== 8'h00) begin miscompares++; $display("FAIL b2b_first_data got=%h exp=00", prev_dv_data); end
    vectors++; if (last_dv_data !== 8'hFF) begin miscompares++; $display("FAIL b2b_second_data got=%h exp=ff", last_dv_data); end
  endtask

  task automatic test_reset_mid_frame;
    int n, dv0, fe0;
    logic [7:0] b;
    b = 8'hC7;
    align(n);
    dv0 = dv_count; fe0 = fe_count;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(BIT_NS / 2);
    reset = 1'b0;
    #1;
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL rst_mid_data_out got=%h exp=00", data_out); end
    vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL rst_mid_running got=%b exp=0", running); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_data_valid got=%b exp=0", data_valid); end
    vectors++; if (framing_error !== 1'b0) begin miscompares++; $display("FAIL rst_mid_framing_error got=%b exp=0", framing_error); end
    rx = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(10);
    vectors++; if (dv_count - dv0 !== 0) begin miscompares++; $display("FAIL rst_mid_no_dv got=%0d exp=0", dv_count - dv0); end
    vectors++; if (fe_count - fe0 !== 0) begin miscompares++; $display("FAIL rst_mid_no_fe got=%0d exp=0", fe_count - fe0); end
    align(n);
    dv0 = dv_count;
    send_frame(8'h3C, BIT_NS, 1'b1, BIT_NS);
    idle(20);
    vectors++; if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL rst_mid_recover_dv got=%0d exp=1", dv_count - dv0); end
    vectors++; if (data_out !== 8'h3C) begin miscompares++; $display("FAIL rst_mid_recover_data got=%h exp=3c", data_out); end
  endtask

  task automatic test_baud_mismatch;
    int n, dv0, fe0, bns;
    for (int k = 0; k < 2; k++) begin
      bns = (k == 0) ? 155 : 165;
      align(n);
      dv0 = dv_count; fe0 = fe_count;
      send_frame(8'hA5, bns, 1'b1, bns);
      idle(30);
      vectors++; if (dv_count - dv0 !== 1) begin miscompares++; $display("FAIL baud_%0d_dv got=%0d exp=1", bns, dv_count - dv0); end
      vectors++; if (fe_count - fe0 !== 0) begin miscompares++; $display("FAIL baud_%0d_fe got=%0d exp=0", bns, fe_count - fe0); end
      vectors++; if (data_out !== 8'hA5) begin miscompares++; $display("FAIL baud_%0d_data got=%h exp=a5", bns, data_out); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_mismatch();
    vectors++; if (both_count !== 0) begin miscompares++; $display("FAIL strobe_exclusive got=%0d exp=0", both_count); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
